// File: rtl/alu_nibble_serial.sv
// Nibble-serial 74181-style ALU: one 4-bit slice reused WIDTH/4 times, least-significant nibble first.
// Build with ALU_OVERFLOW_EN defined to add the signed-overflow output port.
module alu_nibble_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             carry_out,
  output logic             zero,
`ifdef ALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or DONE);
  // done pulses for one cycle when f/flags are loaded, and a start in that cycle is accepted.

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("alu_nibble_serial: WIDTH must be a positive multiple of 4");
  end

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef ALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             slice_c3;
`endif

  logic [IDX_W+1:0] bit_base;
  logic [3:0]       a_nib, b_nib, x_nib, y_nib, slice_f;
  logic [4:0]       slice_sum;
  logic             slice_c4;

  assign bit_base = {idx_q, 2'b00};

  // 74181 slice: arithmetic result is X plus Y plus carry, logic result is ~(X ^ Y),
  // where X and Y are the select-gated operand terms of the original part.
  always_comb begin
    a_nib     = a_q[bit_base +: 4];
    b_nib     = b_q[bit_base +: 4];
    x_nib     = a_nib | (b_nib & {4{sel_q[0]}}) | (~b_nib & {4{sel_q[1]}});
    y_nib     = (a_nib & ~b_nib & {4{sel_q[2]}}) | (a_nib & b_nib & {4{sel_q[3]}});
    slice_sum = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, carry_q};
    slice_f   = mode_q ? ~(x_nib ^ y_nib) : slice_sum[3:0];
    slice_c4  = mode_q ? 1'b0 : slice_sum[4];
  end

`ifdef ALU_OVERFLOW_EN
  assign slice_c3 = mode_q ? 1'b0 : (x_nib[3] ^ y_nib[3] ^ slice_sum[3]);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    f_d      = f_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef ALU_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_RUN: begin
        shadow_d[bit_base +: 4] = slice_f;
        carry_d = slice_c4;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          // Final slice: publish the whole result at once so f never shows a partial value.
          state_d = S_DONE;
          idx_d   = '0;
          f_d     = shadow_d;
          cout_d  = slice_c4;
          zero_d  = (shadow_d == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef ALU_OVERFLOW_EN
          ovf_d   = slice_c3 ^ slice_c4;
`endif
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          mode_d  = mode;
          sel_d   = sel;
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      sel_q    <= 4'h0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      shadow_q <= '0;
      f_q      <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      f_q      <= f_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign f         = f_q;
  assign carry_out = cout_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;
`ifdef ALU_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_serial.sv
// Bench for alu_nibble_serial: WIDTH=8 and WIDTH=16 instances, directed steps plus random ops,
// scoreboard of expected {overflow, zero, carry_out, f}; overflow checked when ALU_OVERFLOW_EN is defined.
module tb_alu_nibble_serial;

  logic clk;
  logic reset;

  logic        start8, mode8, cin8;
  logic [3:0]  sel8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, carry8, zero8, ovf_obs8;
  logic [7:0]  f8;
  logic [1:0]  dbg8;

  logic        start16, mode16, cin16;
  logic [3:0]  sel16;
  logic [15:0] a16, b16;
  logic        busy16, done16, carry16, zero16, ovf_obs16;
  logic [15:0] f16;
  logic [1:0]  dbg16;

  int vectors;
  int miscompares;
  int done_cnt8;
  int done_cnt16;

  logic [10:0] exp_q8[$];
  logic [18:0] exp_q16[$];

`ifdef ALU_OVERFLOW_EN
  localparam bit HAS_OVF = 1'b1;
  logic ovf8, ovf16;
  assign ovf_obs8  = ovf8;
  assign ovf_obs16 = ovf16;
`else
  localparam bit HAS_OVF = 1'b0;
  assign ovf_obs8  = 1'b0;
  assign ovf_obs16 = 1'b0;
`endif

  alu_nibble_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8), .sel(sel8),
    .a(a8), .b(b8), .carry_in(cin8), .busy(busy8), .done(done8), .f(f8),
    .carry_out(carry8), .zero(zero8),
`ifdef ALU_OVERFLOW_EN
    .overflow(ovf8),
`endif
    .dbg_state(dbg8)
  );

  alu_nibble_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .mode(mode16), .sel(sel16),
    .a(a16), .b(b16), .carry_in(cin16), .busy(busy16), .done(done16), .f(f16),
    .carry_out(carry16), .zero(zero16),
`ifdef ALU_OVERFLOW_EN
    .overflow(ovf16),
`endif
    .dbg_state(dbg16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from the 74181 active-high function table; returns {ovf, zero, cout, f[15:0]}.
  function automatic logic [18:0] model(input int w, input logic m, input logic [3:0] s,
                                        input logic [15:0] av, input logic [15:0] bv, input logic cin);
    logic [15:0] mask, x, y, r;
    logic [16:0] sum, low;
    logic        cout, cmsb, ovf;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    x = 16'h0000;
    y = 16'h0000;
    if (m) begin
      case (s)
        4'h0: r = ~av;
        4'h1: r = ~(av | bv);
        4'h2: r = ~av & bv;
        4'h3: r = 16'h0000;
        4'h4: r = ~(av & bv);
        4'h5: r = ~bv;
        4'h6: r = av ^ bv;
        4'h7: r = av & ~bv;
        4'h8: r = ~av | bv;
        4'h9: r = ~(av ^ bv);
        4'hA: r = bv;
        4'hB: r = av & bv;
        4'hC: r = 16'hFFFF;
        4'hD: r = av | ~bv;
        4'hE: r = av | bv;
        default: r = av;
      endcase
      r = r & mask;
      cout = 1'b0;
      ovf = 1'b0;
    end else begin
      case (s)
        4'h0: begin x = av;        y = 16'h0000;  end
        4'h1: begin x = av | bv;   y = 16'h0000;  end
        4'h2: begin x = av | ~bv;  y = 16'h0000;  end
        4'h3: begin x = 16'hFFFF;  y = 16'h0000;  end
        4'h4: begin x = av;        y = av & ~bv;  end
        4'h5: begin x = av | bv;   y = av & ~bv;  end
        4'h6: begin x = av;        y = ~bv;       end
        4'h7: begin x = av & ~bv;  y = 16'hFFFF;  end
        4'h8: begin x = av;        y = av & bv;   end
        4'h9: begin x = av;        y = bv;        end
        4'hA: begin x = av | ~bv;  y = av & bv;   end
        4'hB: begin x = av & bv;   y = 16'hFFFF;  end
        4'hC: begin x = av;        y = av;        end
        4'hD: begin x = av | bv;   y = av;        end
        4'hE: begin x = av | ~bv;  y = av;        end
        default: begin x = av;     y = 16'hFFFF;  end
      endcase
      sum  = {1'b0, x & mask} + {1'b0, y & mask} + {16'h0000, cin};
      low  = {1'b0, x & (mask >> 1)} + {1'b0, y & (mask >> 1)} + {16'h0000, cin};
      r    = sum[15:0] & mask;
      cout = (w == 16) ? sum[16] : sum[8];
      cmsb = (w == 16) ? low[15] : low[7];
      ovf  = (cmsb ^ cout) & HAS_OVF;
    end
    model = {ovf, (r == 16'h0000), cout, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called just after a falling edge; start is sampled on the following rising edge
  task automatic drive8(input logic m, input logic [3:0] s, input logic [7:0] av, input logic [7:0] bv,
                        input logic cin, input bit push);
    logic [18:0] e;
    mode8 = m; sel8 = s; a8 = av; b8 = bv; cin8 = cin; start8 = 1'b1;
    e = model(8, m, s, {8'h00, av}, {8'h00, bv}, cin);
    if (push) exp_q8.push_back({e[18:16], e[7:0]});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drive16(input logic m, input logic [3:0] s, input logic [15:0] av, input logic [15:0] bv,
                         input logic cin, input bit push);
    mode16 = m; sel16 = s; a16 = av; b16 = bv; cin16 = cin; start16 = 1'b1;
    if (push) exp_q16.push_back(model(16, m, s, av, bv, cin));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic wait_done8(input string tag, input int lat_exp);
    int lat;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check(tag, lat, lat_exp);
  endtask

  task automatic wait_done16(input string tag, input int lat_exp);
    int lat;
    lat = 0;
    while (!done16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check(tag, lat, lat_exp);
  endtask

  // scoreboard: pop and compare on every done pulse
  always @(negedge clk) begin
    if (done8) begin
      done_cnt8++;
      vectors++;
      assert (exp_q8.size() != 0) else begin
        miscompares++;
        $error("FAIL sb8_unexpected_done: observed f=%0h expected no completion", f8);
      end
      if (exp_q8.size() != 0) begin
        logic [10:0] e8;
        e8 = exp_q8.pop_front();
        vectors++;
        assert ({ovf_obs8, zero8, carry8, f8} === e8) else begin
          miscompares++;
          $error("FAIL sb8: observed %0h expected %0h", {ovf_obs8, zero8, carry8, f8}, e8);
        end
      end
    end
    if (done16) begin
      done_cnt16++;
      vectors++;
      assert (exp_q16.size() != 0) else begin
        miscompares++;
        $error("FAIL sb16_unexpected_done: observed f=%0h expected no completion", f16);
      end
      if (exp_q16.size() != 0) begin
        logic [18:0] e16;
        e16 = exp_q16.pop_front();
        vectors++;
        assert ({ovf_obs16, zero16, carry16, f16} === e16) else begin
          miscompares++;
          $error("FAIL sb16: observed %0h expected %0h", {ovf_obs16, zero16, carry16, f16}, e16);
        end
      end
    end
  end

  initial begin
    int cnt;
    vectors = 0; miscompares = 0; done_cnt8 = 0; done_cnt16 = 0;
    reset = 1'b1;
    start8 = 1'b0; mode8 = 1'b0; sel8 = 4'h0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start16 = 1'b0; mode16 = 1'b0; sel16 = 4'h0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset8", {busy8, done8, carry8, zero8, ovf_obs8, f8}, 32'h0);
    check("reset16", {busy16, done16, carry16, zero16, ovf_obs16, f16}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 8-bit add 0x3C + 0x0F
    drive8(1'b0, 4'b1001, 8'h3C, 8'h0F, 1'b0, 1'b1);
    check("t1_busy", busy8, 1);
    wait_done8("t1_latency", 2);
    check("t1_result", {carry8, zero8, f8}, {1'b0, 1'b0, 8'h4B});
    @(negedge clk);
    check("t1_done_pulse", done8, 0);
    check("t1_hold", f8, 8'h4B);

    // wrap to zero with carry out
    drive8(1'b0, 4'b1001, 8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done8("t2_latency", 2);
    check("t2_result", {carry8, zero8, f8}, {1'b1, 1'b1, 8'h00});
    check("t2_ovf", ovf_obs8, 0);
    @(negedge clk);

    // 16-bit logic XOR
    drive16(1'b1, 4'b0110, 16'hA5A5, 16'hFFFF, 1'b0, 1'b1);
    wait_done16("t3_latency", 4);
    check("t3_result", {carry16, zero16, f16}, {1'b0, 1'b0, 16'h5A5A});
    @(negedge clk);

    // start while busy is ignored
    cnt = done_cnt8;
    drive8(1'b0, 4'b1001, 8'h55, 8'h22, 1'b0, 1'b1);
    a8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_done_count", done_cnt8 - cnt, 1);
    check("t4_result", f8, 8'h77);

    // back-to-back: start held in the done cycle
    drive8(1'b0, 4'b1001, 8'h12, 8'h34, 1'b0, 1'b1);
    wait_done8("t5a_latency", 2);
    drive8(1'b0, 4'b0110, 8'h10, 8'h01, 1'b1, 1'b1);
    check("t5_busy_no_gap", {busy8, done8}, 2'b10);
    wait_done8("t5b_latency", 2);
    check("t5_result", {carry8, f8}, {1'b1, 8'h0F});
    @(negedge clk);

    // signed overflow 0x7F + 0x01
    drive8(1'b0, 4'b1001, 8'h7F, 8'h01, 1'b0, 1'b1);
    wait_done8("t7_latency", 2);
    check("t7_result", {ovf_obs8, carry8, f8}, {HAS_OVF, 1'b0, 8'h80});
    @(negedge clk);

    // random operations on both widths
    for (int i = 0; i < 10; i++) begin
      drive8(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done8("rand8_latency", 2);
      @(negedge clk);
      drive16(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
              16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done16("rand16_latency", 4);
      @(negedge clk);
    end

    // reset at E1 of a 16-bit operation aborts it
    cnt = done_cnt16;
    drive16(1'b0, 4'b1001, 16'h1234, 16'h1111, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_cleared", {busy16, done16, carry16, zero16, ovf_obs16, f16}, 32'h0);
    repeat (6) @(negedge clk);
    check("t6_no_done", done_cnt16 - cnt, 0);
    check("t6_idle", busy16, 0);

    repeat (4) @(negedge clk);
    check("q8_drained", exp_q8.size(), 0);
    check("q16_drained", exp_q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
